// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, register_file addressing,
// PC/ALU/memory strobes and a retired-instruction counter. Define MC_CTRL_TRAP_EN to trap on illegal ops.
module mc_control_unit #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              zero,
  output logic [REG_AW-1:0] Ra,
  output logic [REG_AW-1:0] Rb,
  output logic [REG_AW-1:0] Rw,
  output logic              enWrite,
  output logic              imem_req,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [2:0]        alu_op,
  output logic              alu_src_imm,
  output logic              wb_sel,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MC_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] ir, ir_d;
  logic              illegal_d;
  logic              retire;
  logic              jump_q, branch_q;

  logic [3:0]        op, op_d;
  logic [2:0]        rd_d, rs_d, rt_d, funct_d;
  logic              unused_imm;

  assign op         = ir[23:20];
  assign op_d       = ir_d[23:20];
  assign rd_d       = ir_d[19:17];
  assign rs_d       = ir_d[16:14];
  assign rt_d       = ir_d[13:11];
  assign funct_d    = ir_d[2:0];
  assign unused_imm = ^ir[10:3];

  // Next state, instruction latch, sticky illegal flag and retire pulse.
  always_comb begin
    state_d   = state;
    ir_d      = ir;
    illegal_d = illegal;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_req && imem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_J) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op > OP_J) begin
          illegal_d = 1'b1;
`ifdef MC_CTRL_TRAP_EN
          state_d   = S_TRAP;
`else
          retire    = 1'b1;
          state_d   = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_BEQ) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = state;
    endcase
  end

  logic [REG_AW-1:0] ra_d, rb_d, rw_d;
  logic              en_write_d, imem_req_d, dmem_read_d, dmem_write_d;
  logic [1:0]        pc_src_d;
  logic [2:0]        alu_op_d;
  logic              alu_src_imm_d, wb_sel_d, jump_d, branch_d;

  // Moore output decode for the state being entered, so every strobe is a flop output.
  always_comb begin
    ra_d          = '0;
    rb_d          = '0;
    rw_d          = '0;
    en_write_d    = 1'b0;
    imem_req_d    = 1'b0;
    dmem_read_d   = 1'b0;
    dmem_write_d  = 1'b0;
    pc_src_d      = PC_SEQ;
    alu_op_d      = ALU_ADD;
    alu_src_imm_d = 1'b0;
    wb_sel_d      = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    if (state_d == S_FETCH) imem_req_d = 1'b1;
    if (state_d == S_DECODE || state_d == S_EXEC) begin
      ra_d = REG_AW'(rs_d);
      rb_d = REG_AW'(rt_d);
    end
    if (state_d == S_DECODE && op_d == OP_J) begin
      jump_d   = 1'b1;
      pc_src_d = PC_JUMP;
    end
    if (state_d == S_EXEC) begin
      if (op_d == OP_RTYPE) alu_op_d = funct_d;
      else if (op_d == OP_BEQ) alu_op_d = ALU_SUB;
      alu_src_imm_d = (op_d == OP_ADDI) || (op_d == OP_LW) || (op_d == OP_SW);
      if (op_d == OP_BEQ) begin
        branch_d = 1'b1;
        pc_src_d = PC_BRANCH;
      end
    end
    if (state_d == S_MEM) begin
      dmem_read_d  = (op_d == OP_LW);
      dmem_write_d = (op_d == OP_SW);
    end
    if (state_d == S_WB) begin
      rw_d       = REG_AW'(rd_d);
      en_write_d = (rd_d != 3'd0);
      wb_sel_d   = (op_d == OP_LW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ir          <= '0;
      illegal     <= 1'b0;
      retired     <= '0;
      Ra          <= '0;
      Rb          <= '0;
      Rw          <= '0;
      enWrite     <= 1'b0;
      imem_req    <= 1'b0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      pc_src      <= PC_SEQ;
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b0;
      wb_sel      <= 1'b0;
      jump_q      <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      state       <= state_d;
      ir          <= ir_d;
      illegal     <= illegal_d;
      retired     <= retired + CNT_W'(retire);
      Ra          <= ra_d;
      Rb          <= rb_d;
      Rw          <= rw_d;
      enWrite     <= en_write_d;
      imem_req    <= imem_req_d;
      dmem_read   <= dmem_read_d;
      dmem_write  <= dmem_write_d;
      pc_src      <= pc_src_d;
      alu_op      <= alu_op_d;
      alu_src_imm <= alu_src_imm_d;
      wb_sel      <= wb_sel_d;
      jump_q      <= jump_d;
      branch_q    <= branch_d;
    end
  end

  // The PC strobe is the one signal qualified in-cycle: by the fetch handshake and by the branch flag.
  assign pc_write = (imem_req & imem_ready) | jump_q | (branch_q & zero);

endmodule
